// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-RAM port arbiter:
// owner/state encodings, legal parameter ranges, helpers.
package mem_port_arbiter_pkg;

  localparam int RD_LAT_MIN    = 1;
  localparam int RD_LAT_MAX    = 4;
  localparam int BURST_MAX_MIN = 1;
  localparam int BURST_MAX_MAX = 15;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_ACC  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE_OWN = 2'd1,
    ST_ACC_OWN  = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic acc;
  } rd_tag_t;

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic state_e own2st(owner_e o);
    state_e s;
    s = ST_IDLE;
    unique case (o)
      OWN_CORE: s = ST_CORE_OWN;
      OWN_ACC:  s = ST_ACC_OWN;
      default:  s = ST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core, accelerator and RAM-side signals of the arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 64
) ();

  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          acc_req;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_gnt;
  logic          acc_rvalid;
  logic [DW-1:0] acc_rdata;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  core_req, core_we,
    input  core_addr, core_wdata,
    output core_gnt, core_stall,
    output core_rvalid, core_rdata,
    input  acc_req, acc_we,
    input  acc_addr, acc_wdata,
    output acc_gnt,
    output acc_rvalid, acc_rdata,
    output ram_en, ram_we,
    output ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output core_req, core_we,
    output core_addr, core_wdata,
    input  core_gnt, core_stall,
    input  core_rvalid, core_rdata,
    output acc_req, acc_we,
    output acc_addr, acc_wdata,
    input  acc_gnt,
    input  acc_rvalid, acc_rdata,
    input  ram_en, ram_we,
    input  ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rd_return_pipe.sv
// Read-return tag pipeline: {valid, owner} delayed by
// RD_LAT cycles to steer RAM read data to its requester.
module mem_port_arbiter_rd_return_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_acc,
  output logic o_core_rvalid,
  output logic o_acc_rvalid
);

  rd_tag_t r_pipe [RD_LAT];
  rd_tag_t w_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++)
        r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: i_push, acc: i_acc};
      for (int i = 1; i < RD_LAT; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_out         = r_pipe[RD_LAT-1];
  assign o_core_rvalid = w_out.valid & ~w_out.acc;
  assign o_acc_rvalid  = w_out.valid & w_out.acc;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin, burst-limited arbiter sharing one data RAM
// between the core memory port and the accelerator DMA.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW        = 10,
  parameter int DW        = 64,
  parameter int RD_LAT    = 1,
  parameter int BURST_MAX = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT =
    clamp(RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
  localparam int BMAX =
    clamp(BURST_MAX, BURST_MAX_MIN, BURST_MAX_MAX);
  localparam logic [3:0] BURST_LIM = 4'(BMAX - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  owner_e        r_last;
  owner_e        w_owner;
  logic [3:0]    r_burst;
  logic [3:0]    w_burst_nxt;
  logic          w_both;
  logic          w_core_only;
  logic          w_acc_only;
  logic          w_keep;
  logic          w_core_gnt;
  logic          w_acc_gnt;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_wdata;
  logic          w_core_rvalid;
  logic          w_acc_rvalid;
  logic [DW-1:0] r_core_rdata;
  logic [DW-1:0] r_acc_rdata;

  assign w_both      = bus.core_req & bus.acc_req;
  assign w_core_only = bus.core_req & ~bus.acc_req;
  assign w_acc_only  = bus.acc_req & ~bus.core_req;
  assign w_keep      = r_burst < BURST_LIM;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= OWN_ACC;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
      if (w_owner != OWN_NONE)
        r_last <= w_owner;
    end
  end

  // Grants are suppressed while reset is held.
  always_comb begin
    w_owner = OWN_NONE;
    if (!reset) begin
      unique case (1'b1)
        w_both: begin
          unique case (r_state)
            ST_CORE_OWN:
              w_owner = w_keep ? OWN_CORE : OWN_ACC;
            ST_ACC_OWN:
              w_owner = w_keep ? OWN_ACC : OWN_CORE;
            default:
              w_owner = (r_last == OWN_CORE) ?
                        OWN_ACC : OWN_CORE;
          endcase
        end
        w_core_only: w_owner = OWN_CORE;
        w_acc_only:  w_owner = OWN_ACC;
        default:     w_owner = OWN_NONE;
      endcase
    end
    w_state_nxt = own2st(w_owner);
    w_burst_nxt = '0;
    if (w_both && r_state != ST_IDLE &&
        w_state_nxt == r_state)
      w_burst_nxt = r_burst + 4'(r_burst != 4'hF);
  end

  always_comb begin
    w_core_gnt  = (w_owner == OWN_CORE);
    w_acc_gnt   = (w_owner == OWN_ACC);
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    unique case (w_owner)
      OWN_CORE: begin
        w_ram_we    = bus.core_we;
        w_ram_addr  = bus.core_addr;
        w_ram_wdata = bus.core_wdata;
      end
      OWN_ACC: begin
        w_ram_we    = bus.acc_we;
        w_ram_addr  = bus.acc_addr;
        w_ram_wdata = bus.acc_wdata;
      end
      default: ;
    endcase
  end

  assign bus.core_gnt   = w_core_gnt;
  assign bus.acc_gnt    = w_acc_gnt;
  assign bus.core_stall = bus.core_req & ~w_core_gnt;
  assign bus.ram_en     = w_core_gnt | w_acc_gnt;
  assign bus.ram_we     = w_ram_we;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_wdata  = w_ram_wdata;

  mem_port_arbiter_rd_return_pipe #(
    .RD_LAT (LAT)
  ) u_rd_pipe (
    .clk           (clk),
    .reset         (reset),
    .i_push        (bus.ram_en & ~w_ram_we),
    .i_acc         (w_acc_gnt),
    .o_core_rvalid (w_core_rvalid),
    .o_acc_rvalid  (w_acc_rvalid)
  );

  // Each port keeps its last returned word between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_rdata <= '0;
      r_acc_rdata  <= '0;
    end else begin
      if (w_core_rvalid)
        r_core_rdata <= bus.ram_rdata;
      if (w_acc_rvalid)
        r_acc_rdata <= bus.ram_rdata;
    end
  end

  assign bus.core_rvalid = w_core_rvalid;
  assign bus.acc_rvalid  = w_acc_rvalid;
  assign bus.core_rdata  =
    w_core_rvalid ? bus.ram_rdata : r_core_rdata;
  assign bus.acc_rdata   =
    w_acc_rvalid ? bus.ram_rdata : r_acc_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first
// RAM model of RD_LAT cycles read latency.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int RD_LAT = 3;

  typedef struct {
    bit cr;
    bit cw;
    bit ar;
    bit aw;
    bit gc;
    bit ga;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ld = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [63:0] mem [1024];
  logic [63:0] rdp [RD_LAT];

  vec_t tv [$];

  mem_port_arbiter_if #(.AW(10), .DW(64)) bus ();

  mem_port_arbiter #(
    .AW(10), .DW(64),
    .RD_LAT(RD_LAT), .BURST_MAX(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(int a);
    if (a == 32'h100) return 64'hDEADBEEF_00000001;
    return {32'h0BADF00D, 22'd0, 10'(a)};
  endfunction

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (bus.ram_en && bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    rdp[0] <= (bus.ram_en && !bus.ram_we) ?
              mem[bus.ram_addr] : 64'h0;
    for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
  end

  assign bus.ram_rdata = rdp[RD_LAT-1];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.acc_req    = 1'b0;
    bus.acc_we     = 1'b0;
    bus.acc_addr   = '0;
    bus.acc_wdata  = '0;
  endtask

  function automatic vec_t v(bit cr, bit cw, bit ar,
                             bit aw, bit gc, bit ga);
    vec_t t;
    t.cr = cr; t.cw = cw; t.ar = ar; t.aw = aw;
    t.gc = gc; t.ga = ga;
    return t;
  endfunction

  initial begin
    logic [9:0]  ca, aa;
    logic [63:0] cd, ad;
    int cnt;

    idle_in();
    // burst of 4 per side while both request
    for (int i = 0; i < 4; i++) tv.push_back(v(1,0,1,0,1,0));
    for (int i = 0; i < 4; i++) tv.push_back(v(1,0,1,0,0,1));
    for (int i = 0; i < 4; i++) tv.push_back(v(1,0,1,0,1,0));
    for (int i = 0; i < 4; i++) tv.push_back(v(1,0,1,0,0,1));
    for (int i = 0; i < 4; i++) tv.push_back(v(1,0,1,0,1,0));
    tv.push_back(v(0,0,1,0,0,1));
    tv.push_back(v(0,0,1,0,0,1));
    tv.push_back(v(0,0,0,0,0,0));
    tv.push_back(v(1,0,1,0,1,0));
    tv.push_back(v(0,0,1,1,0,1));
    tv.push_back(v(0,0,0,0,0,0));
    tv.push_back(v(1,0,0,0,1,0));
    tv.push_back(v(0,0,0,0,0,0));
    tv.push_back(v(1,0,1,0,0,1));
    tv.push_back(v(0,0,0,0,0,0));

    nxt();
    ld = 1'b0;
    nxt();
    nxt();
    reset = 1'b0;

    @(negedge clk);
    chk("rst core_gnt", 64'(bus.core_gnt), 64'd0);
    chk("rst acc_gnt", 64'(bus.acc_gnt), 64'd0);
    chk("rst ram_en", 64'(bus.ram_en), 64'd0);
    chk("rst core_rvalid", 64'(bus.core_rvalid), 64'd0);
    chk("rst acc_rvalid", 64'(bus.acc_rvalid), 64'd0);
    chk("rst core_stall", 64'(bus.core_stall), 64'd0);
    chk("rst core_rdata", bus.core_rdata, 64'd0);
    chk("rst state", 64'(dut.r_state), 64'(ST_IDLE));
    nxt();

    foreach (tv[i]) begin
      ca = 10'h100 + 10'(i);
      aa = 10'h200 + 10'(i);
      cd = 64'hC0C0_0000_0000_0000 | 64'(i);
      ad = 64'hACAC_0000_0000_0000 | 64'(i);
      bus.core_req   = tv[i].cr;
      bus.core_we    = tv[i].cw;
      bus.core_addr  = ca;
      bus.core_wdata = cd;
      bus.acc_req    = tv[i].ar;
      bus.acc_we     = tv[i].aw;
      bus.acc_addr   = aa;
      bus.acc_wdata  = ad;
      @(negedge clk);
      chk($sformatf("v%0d core_gnt", i),
          64'(bus.core_gnt), 64'(tv[i].gc));
      chk($sformatf("v%0d acc_gnt", i),
          64'(bus.acc_gnt), 64'(tv[i].ga));
      chk($sformatf("v%0d core_stall", i),
          64'(bus.core_stall), 64'(tv[i].cr & !tv[i].gc));
      chk($sformatf("v%0d ram_en", i),
          64'(bus.ram_en), 64'(tv[i].gc | tv[i].ga));
      chk($sformatf("v%0d ram_addr", i),
          64'(bus.ram_addr),
          tv[i].gc ? 64'(ca) : tv[i].ga ? 64'(aa) : 64'd0);
      chk($sformatf("v%0d ram_we", i),
          64'(bus.ram_we),
          tv[i].gc ? 64'(tv[i].cw) :
          tv[i].ga ? 64'(tv[i].aw) : 64'd0);
      chk($sformatf("v%0d ram_wdata", i),
          bus.ram_wdata,
          tv[i].gc ? cd : tv[i].ga ? ad : 64'd0);
      nxt();
    end
    idle_in();
    for (int k = 0; k < RD_LAT + 2; k++) nxt();

    @(negedge clk);
    chk("hold core_rdata", bus.core_rdata, pat(32'h11A));
    chk("hold acc_rdata", bus.acc_rdata, pat(32'h21C));
    nxt();

    // single core read
    bus.core_req  = 1'b1;
    bus.core_addr = 10'h100;
    @(negedge clk);
    chk("rd core_gnt", 64'(bus.core_gnt), 64'd1);
    chk("rd core_stall", 64'(bus.core_stall), 64'd0);
    chk("rd ram_addr", 64'(bus.ram_addr), 64'h100);
    nxt();
    idle_in();
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      chk($sformatf("rd core_rvalid t%0d", k),
          64'(bus.core_rvalid), 64'(k == RD_LAT));
      chk($sformatf("rd acc_rvalid t%0d", k),
          64'(bus.acc_rvalid), 64'd0);
      if (k >= RD_LAT)
        chk($sformatf("rd core_rdata t%0d", k),
            bus.core_rdata, 64'hDEADBEEF_00000001);
      nxt();
    end
    chk("rd acc_rdata kept", bus.acc_rdata, pat(32'h21C));

    // acc write then core read of the same word
    bus.acc_req   = 1'b1;
    bus.acc_we    = 1'b1;
    bus.acc_addr  = 10'h200;
    bus.acc_wdata = 64'h5A5A;
    @(negedge clk);
    chk("wr acc_gnt", 64'(bus.acc_gnt), 64'd1);
    chk("wr ram_we", 64'(bus.ram_we), 64'd1);
    chk("wr ram_wdata", bus.ram_wdata, 64'h5A5A);
    nxt();
    idle_in();
    bus.core_req  = 1'b1;
    bus.core_addr = 10'h200;
    @(negedge clk);
    chk("wr/rd core_gnt", 64'(bus.core_gnt), 64'd1);
    nxt();
    idle_in();
    cnt = 0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      if (bus.acc_rvalid) cnt++;
      chk($sformatf("wr/rd core_rvalid t%0d", k),
          64'(bus.core_rvalid), 64'(k == RD_LAT));
      if (k == RD_LAT)
        chk("wr/rd core_rdata", bus.core_rdata, 64'h5A5A);
      nxt();
    end
    chk("wr acc_rvalid count", 64'(cnt), 64'd0);

    // back-to-back core then acc reads return in order
    bus.core_req  = 1'b1;
    bus.core_addr = 10'h101;
    @(negedge clk);
    chk("b2b core_gnt", 64'(bus.core_gnt), 64'd1);
    nxt();
    idle_in();
    bus.acc_req  = 1'b1;
    bus.acc_addr = 10'h202;
    @(negedge clk);
    chk("b2b acc_gnt", 64'(bus.acc_gnt), 64'd1);
    nxt();
    idle_in();
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge clk);
      chk($sformatf("b2b core_rvalid t%0d", k),
          64'(bus.core_rvalid), 64'(k == RD_LAT - 1));
      chk($sformatf("b2b acc_rvalid t%0d", k),
          64'(bus.acc_rvalid), 64'(k == RD_LAT));
      if (k == RD_LAT - 1)
        chk("b2b core_rdata", bus.core_rdata, pat(32'h101));
      if (k == RD_LAT)
        chk("b2b acc_rdata", bus.acc_rdata, pat(32'h202));
      nxt();
    end

    // reset while a core read is in flight
    bus.core_req  = 1'b1;
    bus.core_addr = 10'h103;
    @(negedge clk);
    chk("mid core_gnt", 64'(bus.core_gnt), 64'd1);
    nxt();
    idle_in();
    reset = 1'b1;
    @(negedge clk);
    cnt = bus.core_rvalid ? 1 : 0;
    nxt();
    reset = 1'b0;
    for (int k = 0; k < RD_LAT + 2; k++) begin
      @(negedge clk);
      if (bus.core_rvalid) cnt++;
      nxt();
    end
    chk("mid flushed rvalids", 64'(cnt), 64'd0);
    bus.core_req = 1'b1;
    bus.acc_req  = 1'b1;
    @(negedge clk);
    chk("post-rst tie core_gnt", 64'(bus.core_gnt), 64'd1);
    chk("post-rst tie acc_gnt", 64'(bus.acc_gnt), 64'd0);
    nxt();
    idle_in();
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared 64-bit single-port data RAM between two requesters: the core datapath's external memory port (addresses with bits [9:8] != 0) and a hardware-accelerator DMA port.
- Grants one access per cycle, with round-robin fairness and a bounded burst length.
- Returns read data to the winning requester after a fixed RAM latency.
- Produces core_stall, which the top level ANDs into the datapath pc_en so the core freezes while it is denied.

Parameters:
- AW, 10, address width (matches core mem_addr_out)
- DW, 64, data width
- RD_LAT, 1, RAM read latency in cycles (1..4)
- BURST_MAX, 4, max consecutive grants to one requester while the other is requesting (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- core_req  in  1  core access request (level, held until granted)
- core_we  in  1  core write enable
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_gnt  out  1  core access accepted this cycle
- core_stall  out  1  core_req & !core_gnt (combinational)
- core_rvalid  out  1  core read data valid
- core_rdata  out  DW  core read data
- acc_req, acc_we, acc_addr, acc_wdata  in  1/1/AW/DW  accelerator request side, same rules as core
- acc_gnt  out  1  accelerator access accepted
- acc_rvalid  out  1  accelerator read data valid
- acc_rdata  out  DW  accelerator read data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid RD_LAT cycles after ram_en & !ram_we

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset state:
  - All registered outputs 0.
  - FSM in IDLE; last_owner = ACC, so the core wins the first tie.
  - burst_cnt = 0; read-return pipeline cleared.
- FSM states: IDLE, CORE_OWN, ACC_OWN. State encodes the owner of the current cycle's grant.
- Arbitration is combinational from the current requests and registered state; grant is same-cycle.
  - Only one requester: it wins.
  - Both requesting in IDLE: the requester opposite last_owner wins.
  - Both requesting while X owns: X keeps the grant while burst_cnt < BURST_MAX - 1. Otherwise the other requester wins and burst_cnt resets to 0.
  - No requests: go to IDLE, ram_en = 0; last_owner is retained.
- burst_cnt:
  - Increments on each consecutive grant to the same owner while the other is requesting.
  - Resets to 0 on owner change or when the other side is not requesting.
  - Saturates; never wraps.
- RAM outputs: ram_en = core_gnt | acc_gnt. ram_we, ram_addr and ram_wdata are muxed from the granted port. When ram_en = 0, address and data hold 0.
- At most one of core_gnt and acc_gnt is high in any cycle. A grant is a completed handshake: the requester may change its request the next cycle.
- Read return:
  - On each granted read, an owner-tag bit plus valid bit is pushed into an RD_LAT-deep shift pipeline.
  - At the output, the owner's rvalid pulses for 1 cycle with rdata = ram_rdata. The other port's rdata holds its previous value.
  - Writes produce no rvalid.
- Core and accelerator reads may be granted back-to-back. Return order equals grant order.
- Back-to-back reads to the same address return the same data. A write followed by a read (either port, next cycle) returns the new data: the RAM is write-first, and the arbiter adds no bypass.
- A reset mid-transfer flushes the pending read pipeline; no rvalid is issued for reads in flight.
- core_stall is combinational. The datapath pc_en must be gated with !core_stall at the top level.

Decomposition:
- Shared package:
  - owner enum (OWN_NONE, OWN_CORE, OWN_ACC)
  - FSM state encoding
  - RD_LAT and BURST_MAX legal-range constants
- Sub-module rd_return_pipe: parameterised RD_LAT shift register of {valid, owner}, with sync clear. It drives core_rvalid and acc_rvalid.

Test Plan:
- Reset then idle: hold reset 3 cycles, no requests -> all grants, rvalids and ram_en are 0; state IDLE.
- Single core read: core_req=1, core_addr=0x100, ram_rdata model returns 0xDEADBEEF_00000001 -> core_gnt in the same cycle, core_stall=0, core_rvalid exactly RD_LAT cycles later with that data; acc_rvalid stays 0.
- Simultaneous first requests: both request in the cycle after reset -> core granted first (last_owner=ACC); the next cycle, with both still requesting and BURST_MAX=4, the core keeps its grant until 4 consecutive grants; acc_gnt on the 5th; core_stall=1 only in the cycles it is denied.
- Burst fairness: acc streams 10 reads while core requests continuously -> grant pattern is 4 ACC, 4 CORE, 4 ACC, ...; no starvation beyond BURST_MAX cycles.
- Write then read: acc writes 0x5A5A at 0x200, core reads 0x200 the next cycle -> core_rdata = 0x5A5A after RD_LAT; no rvalid for the write.
- Reset mid-read: RD_LAT=3, grant a core read, assert reset 1 cycle later -> no core_rvalid ever appears for that read; first post-reset grant goes to the core on a tie.
